// File: rtl/spi_frame_sequencer.sv
// Chooses which camera frames go out over SPI, picks the 1-in-DECIM x DECIM pixels,
// and keeps one pixel in a hold register so the SPI sender can apply back-pressure.
module spi_frame_sequencer #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 360,
   parameter int DECIM_LOG2   = 2,
   parameter int HCOUNT_WIDTH = 10,
   parameter int VCOUNT_WIDTH = 9,
   parameter int DATA_WIDTH   = 8,
   parameter int SKIP_WIDTH   = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    enable_in,
   input  logic [SKIP_WIDTH-1:0]   skip_in,
   input  logic                    pixel_valid_in,
   input  logic [HCOUNT_WIDTH-1:0] hcount_in,
   input  logic [VCOUNT_WIDTH-1:0] vcount_in,
   input  logic [DATA_WIDTH-1:0]   pixel_data_in,
   input  logic                    spi_ready_in,
   output logic                    trigger_out,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [HCOUNT_WIDTH-1:0] hcount_out,
   output logic [VCOUNT_WIDTH-1:0] vcount_out,
   output logic                    frame_start_out,
   output logic                    line_end_out,
   output logic                    frame_done_out,
   output logic [15:0]             frames_sent_out,
   output logic [15:0]             overruns_out,
   output logic [14:0]             last_frame_pixels_out,
   output logic                    busy_out
);

   localparam int DECIM = 1 << DECIM_LOG2;
   localparam logic [HCOUNT_WIDTH-1:0] H_LIM  = HCOUNT_WIDTH'(H_ACTIVE);
   localparam logic [VCOUNT_WIDTH-1:0] V_LIM  = VCOUNT_WIDTH'(V_ACTIVE);
   localparam logic [HCOUNT_WIDTH-1:0] H_LAST = HCOUNT_WIDTH'(H_ACTIVE - DECIM);
   localparam logic [VCOUNT_WIDTH-1:0] V_LAST = VCOUNT_WIDTH'(V_ACTIVE - DECIM);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [SKIP_WIDTH-1:0]   skip_q;
   logic                    full_q;
   logic                    aborted_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [HCOUNT_WIDTH-1:0] hcount_q;
   logic [VCOUNT_WIDTH-1:0] vcount_q;
   logic [14:0]             pix_cnt_q, last_pix_q;
   logic [15:0]             sent_q, ovr_q;
   logic                    done_q;

   logic sel_w, fs_w, last_w, trig_w;
   logic accept_w, abort_w, start_w, skip_dec_w, drain_done_w;

   assign sel_w  = pixel_valid_in
                && (hcount_in[DECIM_LOG2-1:0] == '0) && (vcount_in[DECIM_LOG2-1:0] == '0)
                && (hcount_in < H_LIM) && (vcount_in < V_LIM);
   assign fs_w   = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
   assign last_w = sel_w && (hcount_in == H_LAST) && (vcount_in == V_LAST);
   // Launch is combinational on the hold so a pixel can go out the cycle after it arrives.
   assign trig_w = full_q && spi_ready_in && !rst_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (enable_in) state_d = S_WAIT;
         S_WAIT:   if (!enable_in) state_d = S_IDLE;
                   else if (fs_w && skip_q == '0) state_d = S_STREAM;
         S_STREAM: if (fs_w || last_w) state_d = S_DRAIN;
         S_DRAIN:  if (!full_q && spi_ready_in) state_d = enable_in ? S_WAIT : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      accept_w     = 1'b0;
      abort_w      = 1'b0;
      start_w      = 1'b0;
      skip_dec_w   = 1'b0;
      drain_done_w = 1'b0;
      busy_out     = 1'b0;
      case (state_q)
         S_WAIT: if (enable_in && fs_w) begin
            if (skip_q == '0) begin
               start_w  = 1'b1;
               accept_w = 1'b1;
            end else begin
               skip_dec_w = 1'b1;
            end
         end
         S_STREAM: begin
            busy_out = 1'b1;
            if (fs_w)       abort_w  = 1'b1;
            else if (sel_w) accept_w = 1'b1;
         end
         S_DRAIN: begin
            busy_out     = 1'b1;
            drain_done_w = !full_q && spi_ready_in;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         skip_q     <= '0;
         full_q     <= 1'b0;
         aborted_q  <= 1'b0;
         data_q     <= '0;
         hcount_q   <= '0;
         vcount_q   <= '0;
         pix_cnt_q  <= '0;
         last_pix_q <= '0;
         sent_q     <= '0;
         ovr_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         if (start_w)         skip_q <= skip_in;
         else if (skip_dec_w) skip_q <= skip_q - 1'b1;

         // A pixel arriving while the old one is launching replaces it.
         if (accept_w && (!full_q || trig_w)) begin
            full_q   <= 1'b1;
            data_q   <= pixel_data_in;
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
         end else if (trig_w) begin
            full_q <= 1'b0;
         end

         if (accept_w && full_q && !trig_w && ovr_q != 16'hFFFF) ovr_q <= ovr_q + 16'd1;

         if (start_w)     pix_cnt_q <= '0;
         else if (trig_w) pix_cnt_q <= pix_cnt_q + 15'd1;

         if (start_w)      aborted_q <= 1'b0;
         else if (abort_w) aborted_q <= 1'b1;

         done_q <= drain_done_w && !aborted_q;
         if (drain_done_w && !aborted_q) begin
            sent_q     <= sent_q + 16'd1;
            last_pix_q <= pix_cnt_q;
         end
      end
   end

   assign trigger_out           = trig_w;
   assign data_out              = data_q;
   assign hcount_out            = hcount_q;
   assign vcount_out            = vcount_q;
   assign frame_start_out       = trig_w && (hcount_q == '0) && (vcount_q == '0);
   assign line_end_out          = trig_w && (hcount_q == H_LAST);
   assign frame_done_out        = done_q;
   assign frames_sent_out       = sent_q;
   assign overruns_out          = ovr_q;
   assign last_frame_pixels_out = last_pix_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer on a reduced 32x16 raster (8x4 = 32 pixels/frame).
module tb_spi_frame_sequencer;

   localparam int H = 32;
   localparam int V = 16;
   localparam int FPIX = 32;

   logic        clk = 1'b0;
   logic        rst, en, pv, rdy;
   logic [3:0]  skip;
   logic [9:0]  hc;
   logic [8:0]  vc;
   logic [7:0]  pd;
   logic        trig, fs, le, fd, busy;
   logic [7:0]  dout;
   logic [9:0]  hout;
   logic [8:0]  vout;
   logic [15:0] sent, ovr;
   logic [14:0] lastpix;

   int n_cmp = 0, n_err = 0;
   int trig_cnt = 0, fs_cnt = 0, le_cnt = 0, fd_cnt = 0, bad_cnt = 0;
   logic first_trig, first_fs;
   logic [7:0] first_data;
   int t0, f0, l0, d0, s0;

   always #5 clk = ~clk;

   spi_frame_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk_in(clk), .rst_in(rst), .enable_in(en), .skip_in(skip),
      .pixel_valid_in(pv), .hcount_in(hc), .vcount_in(vc), .pixel_data_in(pd),
      .spi_ready_in(rdy), .trigger_out(trig), .data_out(dout), .hcount_out(hout),
      .vcount_out(vout), .frame_start_out(fs), .line_end_out(le), .frame_done_out(fd),
      .frames_sent_out(sent), .overruns_out(ovr), .last_frame_pixels_out(lastpix),
      .busy_out(busy));

   function automatic logic [7:0] pix(input logic [9:0] h, input logic [8:0] v);
      return h[7:0] * 8'd3 + v[7:0] * 8'd5 + 8'h11;
   endfunction

   // Every launched pixel must be a subsampled one carrying its own data.
   always @(negedge clk) begin
      if (trig) begin
         trig_cnt <= trig_cnt + 1;
         if (dout !== pix(hout, vout) || hout[1:0] != 2'b00 || vout[1:0] != 2'b00)
            bad_cnt <= bad_cnt + 1;
      end
      if (fs) fs_cnt <= fs_cnt + 1;
      if (le) le_cnt <= le_cnt + 1;
      if (fd) fd_cnt <= fd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_px(input int h, input int v);
      pv = 1'b1;
      hc = 10'(h);
      vc = 9'(v);
      pd = pix(10'(h), 9'(v));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      pv = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Rows v0..v1-1 plus 4 out-of-window columns per row; enable drops at (0,dis_line).
   task automatic drive_frame(input int v0, input int v1, input int dis_line);
      for (int v = v0; v < v1; v++) begin
         for (int h = 0; h < H + 4; h++) begin
            if (v == dis_line && h == 0) en = 1'b0;
            send_px(h, v);
            if (v == 0 && h == 0) begin
               first_trig = trig;
               first_fs   = fs;
               first_data = dout;
            end
         end
      end
      idle(8);
   endtask

   task automatic snap();
      t0 = trig_cnt; f0 = fs_cnt; l0 = le_cnt; d0 = fd_cnt; s0 = 32'(sent);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; pv = 1'b0; rdy = 1'b1; skip = 4'd0;
      hc = '0; vc = '0; pd = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_trigger", 32'(trig), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sent", 32'(sent), 0);
      chk("rst_overruns", 32'(ovr), 0);
      chk("rst_lastpix", 32'(lastpix), 0);
      chk("rst_done", 32'(fd), 0);
      chk("rst_data", 32'(dout), 0);

      // Full frame, SPI always ready
      rst = 1'b0; en = 1'b1;
      idle(3);
      snap();
      drive_frame(0, V, -1);
      chk("full_first_trig", 32'(first_trig), 1);
      chk("full_first_fs", 32'(first_fs), 1);
      chk("full_first_data", 32'(first_data), 32'h11);
      chk("full_triggers", 32'(trig_cnt - t0), FPIX);
      chk("full_frame_starts", 32'(fs_cnt - f0), 1);
      chk("full_line_ends", 32'(le_cnt - l0), 4);
      chk("full_frame_done", 32'(fd_cnt - d0), 1);
      chk("full_lastpix", 32'(lastpix), FPIX);
      chk("full_sent", 32'(sent), 1);
      chk("full_busy_after", 32'(busy), 0);

      // skip=2: frames 0 and 3 of six go out
      skip = 4'd2;
      snap();
      for (int f = 0; f < 6; f++) begin
         t0 = trig_cnt;
         drive_frame(0, V, -1);
         chk("skip_frame_triggers", 32'(trig_cnt - t0), (f == 0 || f == 3) ? FPIX : 0);
      end
      chk("skip_sent", 32'(sent), 3);
      skip = 4'd0;

      // Back-pressure: (0,0) held, (4,0) and (8,0) dropped
      snap();
      rdy = 1'b0;
      for (int h = 0; h < 10; h++) send_px(h, 0);
      chk("ovr_count", 32'(ovr), 2);
      chk("ovr_no_trig", 32'(trig), 0);
      rdy = 1'b1;
      #1;
      chk("ovr_release_trig", 32'(trig), 1);
      chk("ovr_release_data", 32'(dout), 32'(pix(10'd0, 9'd0)));
      chk("ovr_release_fs", 32'(fs), 1);
      for (int h = 10; h < H + 4; h++) send_px(h, 0);
      drive_frame(1, V, -1);
      chk("ovr_triggers", 32'(trig_cnt - t0), FPIX - 2);
      chk("ovr_lastpix", 32'(lastpix), FPIX - 2);
      chk("ovr_sent", 32'(sent), 4);

      // Truncated frame: new (0,0) arrives at row 8
      snap();
      drive_frame(0, 8, -1);
      chk("abort_partial_triggers", 32'(trig_cnt - t0), 16);
      drive_frame(0, V, -1);
      chk("abort_no_done", 32'(fd_cnt - d0), 0);
      chk("abort_sent", 32'(sent), 4);
      chk("abort_lastpix", 32'(lastpix), FPIX - 2);
      chk("abort_busy", 32'(busy), 0);
      snap();
      drive_frame(0, V, -1);
      chk("after_abort_triggers", 32'(trig_cnt - t0), FPIX);
      chk("after_abort_sent", 32'(sent), 5);
      chk("after_abort_lastpix", 32'(lastpix), FPIX);

      // Reset mid-stream with the hold full
      rdy = 1'b0;
      drive_frame(0, 2, -1);
      chk("pre_rst_overruns", 32'(ovr), 9);
      chk("pre_rst_busy", 32'(busy), 1);
      rst = 1'b1; rdy = 1'b1;
      #1;
      chk("rst_cycle_trig", 32'(trig), 0);
      @(posedge clk); #1;
      chk("post_rst_trig", 32'(trig), 0);
      chk("post_rst_sent", 32'(sent), 0);
      chk("post_rst_overruns", 32'(ovr), 0);
      chk("post_rst_lastpix", 32'(lastpix), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_data", 32'(dout), 0);
      rst = 1'b0;
      idle(3);
      snap();
      drive_frame(0, V, -1);
      chk("restart_triggers", 32'(trig_cnt - t0), FPIX);
      chk("restart_fs", 32'(fs_cnt - f0), 1);
      chk("restart_sent", 32'(sent), 1);

      // enable dropped mid-frame: frame finishes, next one is ignored
      snap();
      drive_frame(0, V, 8);
      chk("endrop_triggers", 32'(trig_cnt - t0), FPIX);
      chk("endrop_sent", 32'(sent), 2);
      chk("endrop_busy", 32'(busy), 0);
      t0 = trig_cnt;
      drive_frame(0, V, -1);
      chk("disabled_triggers", 32'(trig_cnt - t0), 0);
      chk("disabled_sent", 32'(sent), 2);

      chk("pixel_integrity", 32'(bad_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
